rf_write_arbiter: RTL and testbench
===================================

Name: rf_write_arbiter

Overview:
- Shares the register file's single write port between two writeback requesters:
  - Requester 0: the main multi-cycle datapath writeback.
  - Requester 1: the long-latency unit (mult/div, load return).
- Each requester has a one-entry holding slot with a valid/ready handshake.
- Round-robin arbitration with an age override for same-register ordering.
- Registered write-port outputs, plus a pending-write query for hazard stalls.

Parameters:
- ADDR_W, 5, register index width.
- DATA_W, 32, register data width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- req0_valid  in  1  requester 0 has a write
- req0_ready  out  1  requester 0 transfer accepted this edge when valid&ready
- req0_addr  in  ADDR_W  requester 0 destination register
- req0_data  in  DATA_W  requester 0 write data
- req1_valid  in  1  requester 1 has a write
- req1_ready  out  1  requester 1 accept
- req1_addr  in  ADDR_W  requester 1 destination register
- req1_data  in  DATA_W  requester 1 write data
- RegWrite  out  1  register file write enable (registered)
- Write_register  out  ADDR_W  register file write address (registered)
- Write_data  out  DATA_W  register file write data (registered)
- q_addr  in  ADDR_W  hazard query address
- q_pending  out  1  a write to q_addr is in flight (combinational)
- q_data  out  DATA_W  youngest in-flight data for q_addr; 0 if none

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high; port name is reset.
- Reset state:
  - Both slots empty.
  - Age bit = 0; round-robin pointer rr = 0.
  - RegWrite = 0, Write_register = 0, Write_data = 0.
  - req0_ready = req1_ready = 1.
- Reset mid-operation: all held writes and any registered write are discarded. No RegWrite pulse is issued in the cycle after reset.
- Ready rule: reqN_ready = ~slotN_full | grantN. A granted slot can refill on the same edge, so one-per-cycle throughput is sustained.
- Accept with reqN_addr == 0: the handshake completes and the write is discarded. The slot is not filled and RegWrite never fires.
- Latency:
  - Accept at edge E0 fills the slot.
  - The grant is computed in the following cycle.
  - Output registers load at E1; RegWrite is high for exactly one cycle.
  - The register file commits at E2.
  - Minimum latency is therefore 2 edges from accept to commit.
- Grant selection each cycle:
  - Only one slot full: grant it.
  - Both full and slot addresses equal: grant the older slot (age bit). Same-register writes commit in arrival order.
  - Both full, different addresses: grant slot rr. On a contested grant, rr toggles to the other requester.
  - Neither full: no grant. RegWrite = 0 next cycle; Write_register and Write_data hold their previous values.
- Age tracking:
  - Age bit records which slot was filled first.
  - Simultaneous fills in the same cycle: slot 0 counts as older, so requester 1's value is final for a shared address.
  - A slot refilled on the cycle it is granted becomes the younger slot.
- Fairness: a full slot waits at most 1 grant. No starvation under continuous requests from both sides.
- Pending query:
  - q_pending = 1 when q_addr != 0 and any of these matches q_addr: RegWrite with Write_register, full slot 0, or full slot 1.
  - q_data priority, youngest first: younger slot, then older slot, then the output register.
  - q_addr == 0 gives q_pending = 0 and q_data = 0.

Decomposition:
- Shared package holds: ADDR_W/DATA_W defaults, the REG_ZERO constant, and the requester-index constants REQ_DP = 0 and REQ_LL = 1.
- One natural sub-module: rf_wb_slot. It is the one-entry holding register with valid/ready, full flag and address/data storage, instantiated twice.
- Arbitration, age, rr and query logic live in the top module.

Test Plan:
- Reset then idle:
  - reset high 2 cycles, then req0_valid=req1_valid=0 for 5 cycles.
  - Required: RegWrite=0 throughout; both ready=1; q_pending=0 for q_addr=5.
- Single write latency:
  - req0 writes addr 3, data 0x1234 at edge E0.
  - Required: RegWrite=1, Write_register=3, Write_data=0x1234 in the cycle after E1 only.
  - Required: q_pending(3)=1 from after E0 until after E2.
- Contested round-robin:
  - Both requesters valid every cycle, addresses r0=4 and r1=7, distinct data per beat.
  - Required: grants alternate 0,1,0,1.
  - Required: each side commits one write per 2 cycles; neither ready stays low more than 1 cycle.
- Same-address ordering:
  - req0 writes (9, 0xA) and req1 writes (9, 0xB) in the same cycle.
  - Required: commits in order 0xA then 0xB; q_data(9)=0xB while both are pending.
- x0 discard:
  - req1 writes addr 0, data 0xFFFF_FFFF.
  - Required: ready=1, no RegWrite pulse, q_pending(0)=0.
- Reset mid-operation:
  - Both slots full; assert reset for one edge.
  - Required: no RegWrite in the following cycle; slots empty; next accepted req1 write (2, 0x55) is granted first (rr=0 with slot 0 empty).

Source files
------------

// File: rtl/rf_write_arbiter_pkg.sv
// rf_write_arbiter_pkg
//   Shared definitions for the register-file write arbiter slice:
//   default address/data widths, the hard-wired zero register index and
//   the requester index constants (datapath = 0, long-latency unit = 1).
package rf_write_arbiter_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 32;

  // Register x0 is hard-wired to zero; writes to it are dropped.
  localparam logic [ADDR_W_DEF-1:0] REG_ZERO = {ADDR_W_DEF{1'b0}};

  // Requester indices, also used as the encoding of the age bit and rr pointer.
  localparam logic REQ_DP = 1'b0;
  localparam logic REQ_LL = 1'b1;

  // Index of the requester that is not idx.
  function automatic logic other_req(input logic idx);
    return (idx == REQ_DP) ? REQ_LL : REQ_DP;
  endfunction

endpackage

// File: rtl/rf_wb_slot.sv
// rf_wb_slot
//   One-entry writeback holding register with a valid/ready handshake.
//   A write is accepted when in_valid & in_ready. Writes to x0 complete
//   the handshake but are never stored. A granted slot may refill on the
//   same edge it drains.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   in_valid/in_ready   handshake with the requester
//   in_addr/in_data     incoming destination register and data
//   grant               slot is drained by the arbiter this cycle
//   full, addr, data    current slot contents
//   fill                slot loads a new entry on the coming edge
module rf_wb_slot
  import rf_write_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              grant,
  output logic              in_ready,
  output logic              full,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data,
  output logic              fill
);

  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(REG_ZERO);

  logic              full_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] data_r;
  logic              ready_s;
  logic              fill_s;

  // Handshake: free when empty or drained this cycle; x0 writes are not stored.
  always_comb begin
    ready_s = ~full_r | grant;
    fill_s  = in_valid & ready_s & (in_addr != ZERO_A);
  end

  // Slot storage: a new fill takes precedence over the drain of the old entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      full_r <= 1'b0;
      addr_r <= {ADDR_W{1'b0}};
      data_r <= {DATA_W{1'b0}};
    end else if (fill_s) begin
      full_r <= 1'b1;
      addr_r <= in_addr;
      data_r <= in_data;
    end else if (grant) begin
      full_r <= 1'b0;
    end
  end

  assign in_ready = ready_s;
  assign fill     = fill_s;
  assign full     = full_r;
  assign addr     = addr_r;
  assign data     = data_r;

endmodule

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter
//   Shares the register file's single write port between the main datapath
//   writeback (requester 0) and the long-latency unit (requester 1).
//   Each requester owns a one-entry slot. Each cycle one full slot is
//   granted: a lone full slot wins; with both full, equal addresses go to
//   the older slot (arrival order) and different addresses go to the
//   round-robin pointer, which then moves to the loser. The grant loads
//   the registered write port, so RegWrite pulses for one cycle.
//   A combinational query reports whether a write to q_addr is in flight
//   and forwards the youngest such data.
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   reqN_valid/ready/addr/data         requester handshakes (N = 0, 1)
//   RegWrite/Write_register/Write_data registered register-file write port
//   q_addr/q_pending/q_data            hazard query
module rf_write_arbiter
  import rf_write_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] Write_register,
  output logic [DATA_W-1:0] Write_data,
  input  logic [ADDR_W-1:0] q_addr,
  output logic              q_pending,
  output logic [DATA_W-1:0] q_data
);

  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(REG_ZERO);

  logic              full0_s, full1_s, fill0_s, fill1_s;
  logic [ADDR_W-1:0] addr0_s, addr1_s;
  logic [DATA_W-1:0] data0_s, data1_s;
  logic              grant0_s, grant1_s, contested_s, win_s;
  logic              age_r;  // index of the slot filled first
  logic              rr_r;   // requester favoured on the next contested grant
  logic              age_nxt_s, rr_nxt_s;
  logic              reg_write_r;
  logic [ADDR_W-1:0] wr_addr_r;
  logic [DATA_W-1:0] wr_data_r;
  logic              hit_out_s, hit0_s, hit1_s, hit_yng_s, hit_old_s;
  logic [DATA_W-1:0] data_yng_s, data_old_s;

  rf_wb_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot0 (
    .clk      (clk),
    .reset    (reset),
    .in_valid (req0_valid),
    .in_addr  (req0_addr),
    .in_data  (req0_data),
    .grant    (grant0_s),
    .in_ready (req0_ready),
    .full     (full0_s),
    .addr     (addr0_s),
    .data     (data0_s),
    .fill     (fill0_s)
  );

  rf_wb_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot1 (
    .clk      (clk),
    .reset    (reset),
    .in_valid (req1_valid),
    .in_addr  (req1_addr),
    .in_data  (req1_data),
    .grant    (grant1_s),
    .in_ready (req1_ready),
    .full     (full1_s),
    .addr     (addr1_s),
    .data     (data1_s),
    .fill     (fill1_s)
  );

  // Grant selection: lone slot wins; same register -> older; else rr pointer.
  always_comb begin
    grant0_s    = 1'b0;
    grant1_s    = 1'b0;
    win_s       = REQ_DP;
    contested_s = full0_s & full1_s;
    if (contested_s) begin
      if (addr0_s == addr1_s) begin
        win_s = age_r;
      end else begin
        win_s = rr_r;
      end
      grant0_s = (win_s == REQ_DP);
      grant1_s = (win_s == REQ_LL);
    end else if (full0_s) begin
      win_s    = REQ_DP;
      grant0_s = 1'b1;
    end else if (full1_s) begin
      win_s    = REQ_LL;
      grant1_s = 1'b1;
    end else begin
      win_s = REQ_DP;
    end
  end

  // Next age/rr: a fresh fill is younger than a slot that stays occupied.
  always_comb begin
    age_nxt_s = age_r;
    rr_nxt_s  = rr_r;
    if (contested_s) begin
      rr_nxt_s = other_req(win_s);
    end else begin
      rr_nxt_s = rr_r;
    end
    if (fill0_s & fill1_s) begin
      age_nxt_s = REQ_DP;
    end else if (fill0_s) begin
      age_nxt_s = (full1_s & ~grant1_s) ? REQ_LL : REQ_DP;
    end else if (fill1_s) begin
      age_nxt_s = (full0_s & ~grant0_s) ? REQ_DP : REQ_LL;
    end else begin
      age_nxt_s = age_r;
    end
  end

  // Age and round-robin state.
  always_ff @(posedge clk) begin
    if (reset) begin
      age_r <= REQ_DP;
      rr_r  <= REQ_DP;
    end else begin
      age_r <= age_nxt_s;
      rr_r  <= rr_nxt_s;
    end
  end

  // Registered write port: loads on a grant, otherwise holds address/data.
  always_ff @(posedge clk) begin
    if (reset) begin
      reg_write_r <= 1'b0;
      wr_addr_r   <= {ADDR_W{1'b0}};
      wr_data_r   <= {DATA_W{1'b0}};
    end else if (grant0_s | grant1_s) begin
      reg_write_r <= 1'b1;
      wr_addr_r   <= (win_s == REQ_LL) ? addr1_s : addr0_s;
      wr_data_r   <= (win_s == REQ_LL) ? data1_s : data0_s;
    end else begin
      reg_write_r <= 1'b0;
    end
  end

  // Hazard query: youngest slot, then older slot, then the write port.
  always_comb begin
    hit_out_s  = reg_write_r & (wr_addr_r == q_addr);
    hit0_s     = full0_s & (addr0_s == q_addr);
    hit1_s     = full1_s & (addr1_s == q_addr);
    hit_yng_s  = (age_r == REQ_DP) ? hit1_s : hit0_s;
    hit_old_s  = (age_r == REQ_DP) ? hit0_s : hit1_s;
    data_yng_s = (age_r == REQ_DP) ? data1_s : data0_s;
    data_old_s = (age_r == REQ_DP) ? data0_s : data1_s;
    q_pending  = 1'b0;
    q_data     = {DATA_W{1'b0}};
    if (q_addr == ZERO_A) begin
      q_pending = 1'b0;
    end else if (hit_yng_s) begin
      q_pending = 1'b1;
      q_data    = data_yng_s;
    end else if (hit_old_s) begin
      q_pending = 1'b1;
      q_data    = data_old_s;
    end else if (hit_out_s) begin
      q_pending = 1'b1;
      q_data    = wr_data_r;
    end else begin
      q_pending = 1'b0;
    end
  end

  assign RegWrite       = reg_write_r;
  assign Write_register = wr_addr_r;
  assign Write_data     = wr_data_r;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter
//   Scoreboard bench for rf_write_arbiter. The driver keeps a reference
//   model of the two holding slots (with arrival stamps for ordering), the
//   round-robin preference and the write-port contents. Each granted write
//   is pushed into a queue with the edge it must appear after; a separate
//   monitor compares the write port against that queue every cycle.
module tb_rf_write_arbiter;

  logic        clk;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [4:0]  req0_addr, req1_addr;
  logic [31:0] req0_data, req1_data;
  logic        RegWrite;
  logic [4:0]  Write_register;
  logic [31:0] Write_data;
  logic [4:0]  q_addr;
  logic        q_pending;
  logic [31:0] q_data;

  rf_write_arbiter #(.ADDR_W(5), .DATA_W(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .req0_valid     (req0_valid),
    .req0_ready     (req0_ready),
    .req0_addr      (req0_addr),
    .req0_data      (req0_data),
    .req1_valid     (req1_valid),
    .req1_ready     (req1_ready),
    .req1_addr      (req1_addr),
    .req1_data      (req1_data),
    .RegWrite       (RegWrite),
    .Write_register (Write_register),
    .Write_data     (Write_data),
    .q_addr         (q_addr),
    .q_pending      (q_pending),
    .q_data         (q_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    int          e;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   edge_cnt = 0;
  logic chk_en = 1'b0;
  logic mon_en = 1'b0;

  // Reference model state
  logic        m_full [2];
  logic [4:0]  m_addr [2];
  logic [31:0] m_data [2];
  int          m_stamp [2];
  int          seq = 0;
  logic        m_rr = 1'b0;
  logic        m_out_v = 1'b0;
  logic [4:0]  m_out_a = 5'd0;
  logic [31:0] m_out_d = 32'd0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", nm, act, exp, edge_cnt);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      m_full[i]  = 1'b0;
      m_addr[i]  = 5'd0;
      m_data[i]  = 32'd0;
      m_stamp[i] = 0;
    end
    m_rr    = 1'b0;
    m_out_v = 1'b0;
    m_out_a = 5'd0;
    m_out_d = 32'd0;
  endtask

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Monitor: one write-port comparison per cycle against the scoreboard.
  logic mon_exp;
  exp_t mon_item;
  always @(negedge clk) begin
    if (mon_en) begin
      mon_exp = (sb.size() > 0) && (sb[0].e == edge_cnt);
      chk("regwrite", 32'(RegWrite), 32'(mon_exp));
      if (mon_exp) begin
        mon_item = sb.pop_front();
        chk("commit_addr", 32'(Write_register), 32'(mon_item.a));
        chk("commit_data", Write_data, mon_item.d);
      end
    end
  end

  // One cycle: drive inputs, check ready/query/held outputs, advance the model.
  task automatic step(input logic rst,
                      input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                      input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                      input logic [4:0] qa);
    int          g;
    int          best;
    logic        r0, r1, ep;
    logic [31:0] ed;
    reset      = rst;
    req0_valid = v0;
    req0_addr  = a0;
    req0_data  = d0;
    req1_valid = v1;
    req1_addr  = a1;
    req1_data  = d1;
    q_addr     = qa;
    #1;
    g = -1;
    if (m_full[0] && m_full[1]) begin
      if (m_addr[0] == m_addr[1]) g = (m_stamp[0] < m_stamp[1]) ? 0 : 1;
      else g = m_rr ? 1 : 0;
    end else if (m_full[0]) begin
      g = 0;
    end else if (m_full[1]) begin
      g = 1;
    end
    r0 = !m_full[0] || (g == 0);
    r1 = !m_full[1] || (g == 1);
    ep = 1'b0;
    ed = 32'd0;
    best = -1;
    if (qa != 5'd0) begin
      if (m_out_v && m_out_a == qa) begin
        ep = 1'b1;
        ed = m_out_d;
      end
      for (int i = 0; i < 2; i++) begin
        if (m_full[i] && m_addr[i] == qa && m_stamp[i] > best) begin
          ep   = 1'b1;
          ed   = m_data[i];
          best = m_stamp[i];
        end
      end
    end
    if (chk_en) begin
      chk("req0_ready", 32'(req0_ready), 32'(r0));
      chk("req1_ready", 32'(req1_ready), 32'(r1));
      chk("q_pending", 32'(q_pending), 32'(ep));
      chk("q_data", q_data, ed);
      chk("held_addr", 32'(Write_register), 32'(m_out_a));
      chk("held_data", Write_data, m_out_d);
    end
    if (rst) begin
      model_clear();
    end else begin
      if (g >= 0) begin
        if (m_full[0] && m_full[1]) m_rr = (g == 0);
        sb.push_back('{m_addr[g], m_data[g], edge_cnt + 1});
        m_out_v   = 1'b1;
        m_out_a   = m_addr[g];
        m_out_d   = m_data[g];
        m_full[g] = 1'b0;
      end else begin
        m_out_v = 1'b0;
      end
      if (v0 && r0 && a0 != 5'd0) begin
        m_full[0] = 1'b1; m_addr[0] = a0; m_data[0] = d0; m_stamp[0] = seq; seq++;
      end
      if (v1 && r1 && a1 != 5'd0) begin
        m_full[1] = 1'b1; m_addr[1] = a1; m_data[1] = d1; m_stamp[1] = seq; seq++;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic [4:0] qa);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, qa);
  endtask

  initial begin
    model_clear();
    reset = 1'b1;
    req0_valid = 1'b0; req0_addr = 5'd0; req0_data = 32'd0;
    req1_valid = 1'b0; req1_addr = 5'd0; req1_data = 32'd0;
    q_addr = 5'd0;

    // Reset two cycles, then idle.
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd5);
    chk_en = 1'b1;
    mon_en = 1'b1;
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd5);
    idle(5, 5'd5);

    // Single write latency.
    step(1'b0, 1'b1, 5'd3, 32'h1234, 1'b0, 5'd0, 32'd0, 5'd3);
    idle(4, 5'd3);

    // Contested round-robin, distinct addresses.
    for (int i = 0; i < 12; i++)
      step(1'b0, 1'b1, 5'd4, 32'h4000 + 32'(i), 1'b1, 5'd7, 32'h7000 + 32'(i), (i % 2 == 0) ? 5'd4 : 5'd7);
    idle(3, 5'd7);

    // Same-address ordering.
    step(1'b0, 1'b1, 5'd9, 32'hA, 1'b1, 5'd9, 32'hB, 5'd9);
    idle(4, 5'd9);

    // x0 discard.
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0);
    idle(3, 5'd0);

    // Randomised traffic with a small address range to force collisions.
    for (int i = 0; i < 400; i++)
      step(1'b0,
           ($urandom_range(0, 9) < 7), 5'($urandom_range(0, 7)), $urandom,
           ($urandom_range(0, 9) < 7), 5'($urandom_range(0, 7)), $urandom,
           5'($urandom_range(0, 7)));
    idle(3, 5'd1);

    // Reset mid-operation with both slots full.
    step(1'b0, 1'b1, 5'd4, 32'h44, 1'b1, 5'd6, 32'h66, 5'd4);
    step(1'b0, 1'b1, 5'd5, 32'h45, 1'b1, 5'd6, 32'h67, 5'd6);
    step(1'b1, 1'b1, 5'd4, 32'h46, 1'b1, 5'd6, 32'h68, 5'd6);
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd2, 32'h55, 5'd6);
    idle(4, 5'd2);

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
